ping_pong_checker: RTL

Receive-side monitor for the 4-bit ping-pong (triangle) count stream produced by our up/down counters. It locks onto the stream, tracks the expected next value with an internal model of the generator, and flags mismatches. It also reports the current direction and keeps completed-period and error statistics. It sits between a counter output (or a bus carrying it) and the status/debug register block.

---
 rtl/ping_pong_pkg.sv | 22 ++
 rtl/ping_pong_model.sv | 35 +++
 rtl/ping_pong_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ping_pong_pkg.sv
// Shared types and constants for the ping-pong count stream checker.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  localparam int unsigned PERIOD_CNT_W = 16;
  localparam int unsigned ERR_CNT_W    = 8;
  localparam int unsigned MISS_CNT_W   = 4;

  localparam logic [PERIOD_CNT_W-1:0] PERIOD_CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0]    ERR_CNT_MAX    = '1;

endpackage

// File: rtl/ping_pong_model.sv
// Combinational next-state model of the up/down (triangle) count generator.
module ping_pong_model
  import ping_pong_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] v,
  input  logic             d,
  output logic [WIDTH-1:0] next_v,
  output logic             next_d,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Each extreme is repeated once; the 0 -> 0 turn closes a period.
  always_comb begin
    next_v = v;
    next_d = d;
    wrap   = 1'b0;
    if (d == UP) begin
      if (v != MAX) next_v = v + ONE;
      else          next_d = DOWN;
    end else begin
      if (v != '0) begin
        next_v = v - ONE;
      end else begin
        next_d = UP;
        wrap   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ping_pong_checker.sv
// Locks onto a ping-pong count stream, predicts the next value and flags mismatches.
// Statistics counters exist only when PING_PONG_CHECKER_STATS_EN is defined.
module ping_pong_checker
  import ping_pong_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [15:0]      period_count,
  output logic [7:0]       err_count
);

  localparam logic [WIDTH-1:0]      MAX      = '1;
  localparam logic [WIDTH-1:0]      ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MISS_CNT_W-1:0] MISS_LIM = MISS_LIMIT[MISS_CNT_W-1:0];
  localparam logic [MISS_CNT_W-1:0] MISS_ONE = {{(MISS_CNT_W-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      s_q, s_d;
  logic                  dir_q, dir_d;
  logic [WIDTH-1:0]      exp_v_q, exp_v_d;
  logic                  exp_d_q, exp_d_d;
  logic                  exp_wrap_q, exp_wrap_d;
  logic [MISS_CNT_W-1:0] miss_q, miss_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic                  period_hit;
  logic                  acquire;

  logic [WIDTH-1:0]      mv, m_next_v;
  logic                  md, m_next_d, m_wrap;

  // The model is fed the state being entered, so the registered prediction
  // is always the value the next valid sample must match.
  ping_pong_model #(.WIDTH(WIDTH)) u_model (
    .v      (mv),
    .d      (md),
    .next_v (m_next_v),
    .next_d (m_next_d),
    .wrap   (m_wrap)
  );

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    dir_d      = dir_q;
    exp_v_d    = exp_v_q;
    exp_d_d    = exp_d_q;
    exp_wrap_d = exp_wrap_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    period_hit = 1'b0;
    acquire    = 1'b0;
    mv         = exp_v_q;
    md         = exp_d_q;

    if (sample_valid) begin
      case (state_q)
        HUNT: begin
          s_d     = sample;
          state_d = ACQ;
        end
        ACQ: begin
          if (s_q != MAX && sample == s_q + ONE) begin
            mv = sample; md = UP; acquire = 1'b1;
          end else if (s_q != '0 && sample == s_q - ONE) begin
            mv = sample; md = DOWN; acquire = 1'b1;
          end else if (sample == s_q && s_q == MAX) begin
            mv = MAX; md = DOWN; acquire = 1'b1;
          end else if (sample == s_q && s_q == '0) begin
            mv = '0; md = UP; acquire = 1'b1;
          end else begin
            s_d = sample;
          end
          if (acquire) begin
            state_d    = LOCK;
            dir_d      = md;
            exp_v_d    = m_next_v;
            exp_d_d    = m_next_d;
            exp_wrap_d = m_wrap;
            miss_d     = '0;
          end
        end
        LOCK: begin
          // Flywheel: the model advances on every valid sample, match or not.
          dir_d      = exp_d_q;
          exp_v_d    = m_next_v;
          exp_d_d    = m_next_d;
          exp_wrap_d = m_wrap;
          if (sample == exp_v_q) begin
            miss_d     = '0;
            period_hit = exp_wrap_q;
          end else begin
            err_d = 1'b1;
            if (miss_q + MISS_ONE == MISS_LIM) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HUNT;
      s_q        <= '0;
      dir_q      <= UP;
      exp_v_q    <= '0;
      exp_d_q    <= UP;
      exp_wrap_q <= 1'b0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      dir_q      <= dir_d;
      exp_v_q    <= exp_v_d;
      exp_d_q    <= exp_d_d;
      exp_wrap_q <= exp_wrap_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign locked   = locked_q;
  assign dir      = dir_q;
  assign expected = exp_v_q;
  assign err      = err_q;

`ifdef PING_PONG_CHECKER_STATS_EN
  logic [PERIOD_CNT_W-1:0] period_q, period_d;
  logic [ERR_CNT_W-1:0]    errc_q, errc_d;

  always_comb begin
    period_d = period_q;
    errc_d   = errc_q;
    if (period_hit && period_q != PERIOD_CNT_MAX) period_d = period_q + 16'd1;
    if (err_d && errc_q != ERR_CNT_MAX)           errc_d   = errc_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q <= '0;
      errc_q   <= '0;
    end else begin
      period_q <= period_d;
      errc_q   <= errc_d;
    end
  end

  assign period_count = period_q;
  assign err_count    = errc_q;
`else
  logic stats_unused;
  assign stats_unused = period_hit;
  assign period_count = '0;
  assign err_count    = '0;
`endif

endmodule
